// File: rtl/spi_master_cs.sv
// SPI master with integrated active-low chip select; bursts of 1..MAX_BYTES_PER_CS bytes per CS window.
// Optional macro SPI_MASTER_CS_TIMEOUT_EN aborts a window left waiting 256 cycles for its next byte.
module spi_master_cs #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 1,
    parameter int MAX_BYTES_PER_CS  = 2,
    parameter int CW                = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_En,
    output logic          o_TX_Ready,
    input  logic [CW-1:0] i_TX_Count,
    output logic [7:0]    o_RX_Byte,
    output logic          o_RX_En,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_SPCK,
    output logic          o_CS_n,
    input  logic          i_MISO,
    output logic          o_MOSI
);

    // state        | meaning
    // S_IDLE       | CS_n high, ready for the first byte of a window
    // S_TRANSFER   | CS_n low, shifting a byte or waiting for the next one
    // S_CS_INACTIVE| CS_n high, enforcing the minimum gap between windows

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   HW   = $clog2(CLKS_PER_HALF_BIT);
    localparam int   IW   = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
    localparam logic [HW-1:0] HALF_RELOAD  = HW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [IW-1:0] INACT_RELOAD = IW'(CS_INACTIVE_CLKS - 1);
    localparam logic [CW-1:0] MAX_CNT      = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [1:0] {S_IDLE, S_TRANSFER, S_CS_INACTIVE} state_t;

    state_t        state, state_nxt;
    logic          busy;
    logic          done_q;
    logic [HW-1:0] half_cnt;
    logic [4:0]    edges_left;
    logic [7:0]    tx_shift;
    logic [7:0]    rx_shift;
    logic [CW-1:0] remaining;
    logic [IW-1:0] inact_cnt;
    logic [CW-1:0] count_clamped;
    logic          waiting;
    logic          accept;
    logic          edge_now;
    logic          leading_edge;
    logic          shift_edge;
    logic          sample_edge;
    logic          timeout_hit;

    assign waiting      = (state == S_TRANSFER) && !busy && (remaining != '0);
    assign accept       = i_TX_En && ((state == S_IDLE) || waiting);
    assign edge_now     = busy && (half_cnt == '0);
    // edges_left counts 16..1, so an even value marks a leading edge
    assign leading_edge = edge_now && !edges_left[0];
    assign shift_edge   = CPHA ? leading_edge
                               : (edge_now && edges_left[0] && (edges_left != 5'd1));
    assign sample_edge  = CPHA ? (edge_now && edges_left[0]) : leading_edge;

    always_comb begin
        count_clamped = i_TX_Count;
        if (i_TX_Count == '0)
            count_clamped = CW'(1);
        else if (int'(i_TX_Count) > MAX_BYTES_PER_CS)
            count_clamped = MAX_CNT;
    end

`ifdef SPI_MASTER_CS_TIMEOUT_EN
    logic [7:0] idle_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_timer <= 8'd0;
        else if (done_q)
            idle_timer <= 8'd255;
        else if (waiting && (idle_timer != 8'd0))
            idle_timer <= idle_timer - 8'd1;
    end

    assign timeout_hit = waiting && !i_TX_En && !done_q && (idle_timer == 8'd0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:        if (accept) state_nxt = S_TRANSFER;
            S_TRANSFER:    if ((!busy && (remaining == '0)) || timeout_hit) state_nxt = S_CS_INACTIVE;
            S_CS_INACTIVE: if (inact_cnt == '0) state_nxt = S_IDLE;
            default:       state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_CS_n     = (state != S_TRANSFER);
        o_TX_Ready = !i_TX_En && ((state == S_IDLE) || waiting);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done_q     <= 1'b0;
            half_cnt   <= HALF_RELOAD;
            edges_left <= 5'd0;
            tx_shift   <= 8'd0;
            rx_shift   <= 8'd0;
            remaining  <= '0;
            inact_cnt  <= INACT_RELOAD;
            o_SPCK     <= CPOL;
            o_MOSI     <= 1'b0;
            o_RX_Byte  <= 8'd0;
            o_RX_En    <= 1'b0;
            o_RX_Count <= '0;
        end else begin
            done_q  <= 1'b0;
            o_RX_En <= 1'b0;

            if (state != S_CS_INACTIVE)
                inact_cnt <= INACT_RELOAD;
            else if (inact_cnt != '0)
                inact_cnt <= inact_cnt - IW'(1);

            if (accept) begin
                busy       <= 1'b1;
                half_cnt   <= HALF_RELOAD;
                edges_left <= 5'd16;
                if (CPHA) begin
                    tx_shift <= i_TX_Byte;
                end else begin
                    tx_shift <= {i_TX_Byte[6:0], 1'b0};
                    o_MOSI   <= i_TX_Byte[7];
                end
                if (state == S_IDLE) begin
                    remaining  <= count_clamped;
                    o_RX_Count <= '0;
                end
            end else if (busy) begin
                if (half_cnt != '0) begin
                    half_cnt <= half_cnt - HW'(1);
                end else begin
                    half_cnt   <= HALF_RELOAD;
                    o_SPCK     <= ~o_SPCK;
                    edges_left <= edges_left - 5'd1;
                    if (shift_edge) begin
                        o_MOSI   <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    if (sample_edge)
                        rx_shift <= {rx_shift[6:0], i_MISO};
                    if (edges_left == 5'd1) begin
                        busy      <= 1'b0;
                        done_q    <= 1'b1;
                        remaining <= remaining - CW'(1);
                    end
                end
            end else if (timeout_hit) begin
                remaining <= '0;
            end

            if (done_q) begin
                o_RX_En   <= 1'b1;
                o_RX_Byte <= rx_shift;
                if (o_RX_Count != MAX_CNT)
                    o_RX_Count <= o_RX_Count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_master_cs.sv
// Bench for spi_master_cs: one looped-back instance per SPI mode, each with its own stimulus and
// a behavioural SPI-slave monitor that decodes MOSI and tracks expected RX bytes and counts.
module tb_spi_master_cs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] b;
        int         cnt;
        int         n_exp;
    } vec_t;

    function automatic void check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic void mark_done();
        done_cnt++;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : u
        localparam logic CPOL_L = (g >= 2);
        localparam logic CPHA_L = ((g % 2) == 1);
        localparam int   C      = (g == 3) ? 5 : 2;
        localparam int   MAX    = (g == 3) ? 7 : 2;
        localparam int   CSI    = (g == 3) ? 1 : 3;
        localparam int   CW     = $clog2(MAX + 1);

        logic          rst_n    = 1'b0;
        logic [7:0]    tx_byte  = 8'd0;
        logic          tx_en    = 1'b0;
        logic [CW-1:0] tx_count = '0;
        logic          tx_ready;
        logic [7:0]    rx_byte;
        logic          rx_en;
        logic [CW-1:0] rx_count;
        logic          spck, cs_n, mosi;

        logic [7:0] exp_q[$];
        logic [7:0] win_data[8];
        logic [7:0] slave_byte     = 8'd0;
        int         edges          = 0;
        int         win_bytes      = 0;
        int         last_win_bytes = 0;
        int         exp_cnt        = 0;
        logic       p_spck         = CPOL_L;
        logic       p_mosi         = 1'b0;
        logic       p_cs           = 1'b1;
        vec_t       vecs[4];

        spi_master_cs #(
            .SPI_MODE(g), .CLKS_PER_HALF_BIT(C),
            .CS_INACTIVE_CLKS(CSI), .MAX_BYTES_PER_CS(MAX)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .i_TX_Byte(tx_byte), .i_TX_En(tx_en), .o_TX_Ready(tx_ready),
            .i_TX_Count(tx_count),
            .o_RX_Byte(rx_byte), .o_RX_En(rx_en), .o_RX_Count(rx_count),
            .o_SPCK(spck), .o_CS_n(cs_n), .i_MISO(mosi), .o_MOSI(mosi)
        );

        function automatic string nm(input string s);
            return $sformatf("m%0d_%s", g, s);
        endfunction

        // SPI-slave view of the bus: a slave samples MOSI on the leading edge for CPHA=0 and the trailing edge for CPHA=1
        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                edges     = 0;
                win_bytes = 0;
                exp_cnt   = 0;
            end else begin
                if (p_cs && !cs_n) begin
                    win_bytes = 0;
                    exp_cnt   = 0;
                    check_eq(nm("rx_count_clear"), int'(rx_count), 0);
                end
                if (spck != p_spck) begin
                    edges++;
                    check_eq(nm("spck_edge_cs_low"), int'(cs_n), 0);
                    if ((p_spck == CPOL_L) != CPHA_L) begin
                        check_eq(nm("mosi_stable_on_sample"), int'(mosi), int'(p_mosi));
                        slave_byte = {slave_byte[6:0], mosi};
                    end
                end else if ((mosi != p_mosi) && !cs_n) begin
                    check_eq(nm("mosi_change_at_byte_start"), int'(!CPHA_L && (edges == 0)), 1);
                end
                if (cs_n)
                    check_eq(nm("spck_idle_cs_high"), int'(spck), int'(CPOL_L));
                if (rx_en) begin
                    win_bytes++;
                    if (exp_cnt < MAX) exp_cnt++;
                    check_eq(nm("edges_per_byte"), edges, 16);
                    edges = 0;
                    check_eq(nm("spck_idle_after_byte"), int'(spck), int'(CPOL_L));
                    check_eq(nm("rx_pending"), exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        check_eq(nm("rx_byte"), int'(rx_byte), int'(exp_q[0]));
                        check_eq(nm("mosi_decoded"), int'(slave_byte), int'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    check_eq(nm("rx_count_step"), int'(rx_count), exp_cnt);
                end
                if (!p_cs && cs_n)
                    last_win_bytes = win_bytes;
            end
            p_spck = spck;
            p_mosi = mosi;
            p_cs   = cs_n;
        end

        task automatic send_byte(input logic [7:0] b, input int cnt, input bit first);
            bit ok;
            bit got;
            ok = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if (tx_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check_eq(nm("ready_wait"), int'(ok), 1);
            if (!ok) return;
            if (!first) check_eq(nm("cs_low_between_bytes"), int'(cs_n), 0);
            tx_byte  = b;
            tx_count = CW'(cnt);
            tx_en    = 1'b1;
            #1 check_eq(nm("ready_low_on_accept"), int'(tx_ready), 0);
            @(posedge clk);
            exp_q.push_back(b);
            @(negedge clk);
            tx_en   = 1'b0;
            tx_byte = 8'($urandom);
            check_eq(nm("cs_low_after_accept"), int'(cs_n), 0);
            got = 1'b0;
            for (int i = 0; i < 16 * C + 8; i++) begin
                @(negedge clk);
                if (rx_en) begin
                    got = 1'b1;
                    break;
                end
            end
            check_eq(nm("rx_en_seen"), int'(got), 1);
        endtask

        task automatic run_window(input int cnt_in, input int n_exp, input int gap);
            int  n, hi;
            bit  gap_ok;
            for (int i = 0; i < n_exp; i++) begin
                send_byte(win_data[i], cnt_in, i == 0);
                if (i != n_exp - 1 && gap > 0) begin
                    gap_ok = 1'b1;
                    for (int k = 0; k < gap; k++) begin
                        @(negedge clk);
                        if (cs_n || (spck != CPOL_L) || !tx_ready) gap_ok = 1'b0;
                    end
                    check_eq(nm("gap_hold"), int'(gap_ok), 1);
                end
            end
            n  = 0;
            hi = 0;
            while (!tx_ready && n < CSI + 20) begin
                if (cs_n) hi++;
                @(negedge clk);
                n++;
            end
            check_eq(nm("ready_after_window"), int'(n >= CSI && n <= CSI + 1), 1);
            check_eq(nm("cs_high_min"), int'(hi >= CSI), 1);
            check_eq(nm("window_bytes"), last_win_bytes, n_exp);
            check_eq(nm("rx_count_hold"), int'(rx_count), n_exp);
        endtask

        initial begin
            int  cnt, n, e;
            bit  reached;
            logic last;

            vecs[0] = '{8'hA5, 1, 1};
            vecs[1] = '{8'h3C, 0, 1};
            vecs[2] = '{8'hC3, (1 << CW) - 1, MAX};
            vecs[3] = '{8'h81, 2, 2};

            rst_n = 1'b0;
            repeat (10) @(negedge clk);
            check_eq(nm("rst_cs_n"), int'(cs_n), 1);
            check_eq(nm("rst_spck"), int'(spck), int'(CPOL_L));
            check_eq(nm("rst_mosi"), int'(mosi), 0);
            check_eq(nm("rst_rx_en"), int'(rx_en), 0);
            check_eq(nm("rst_rx_count"), int'(rx_count), 0);
            rst_n = 1'b1;
            @(negedge clk);
            check_eq(nm("rst_ready"), int'(tx_ready), 1);

            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < vecs[i].n_exp; k++) win_data[k] = vecs[i].b + 8'(k);
                run_window(vecs[i].cnt, vecs[i].n_exp, 0);
            end

            for (int k = 0; k < MAX; k++) win_data[k] = 8'(k + 1);
            run_window(MAX, MAX, 50);

            for (int r = 0; r < 10; r++) begin
                cnt = $urandom_range((1 << CW) - 1, 0);
                n   = (cnt == 0) ? 1 : ((cnt > MAX) ? MAX : cnt);
                for (int k = 0; k < n; k++) win_data[k] = 8'($urandom);
                run_window(cnt, n, $urandom_range(3, 0));
            end

            send_byte(8'h6E, 2, 1'b1);
            tx_byte = 8'h5A;
            tx_en   = 1'b1;
            @(posedge clk);
            exp_q.push_back(8'h5A);
            @(negedge clk);
            tx_en   = 1'b0;
            e       = 0;
            last    = spck;
            reached = 1'b0;
            for (int i = 0; i < 16 * C; i++) begin
                @(negedge clk);
                if (spck != last) begin
                    e++;
                    last = spck;
                end
                if (e == 5) begin
                    reached = 1'b1;
                    break;
                end
            end
            check_eq(nm("fifth_edge_seen"), int'(reached), 1);
            rst_n = 1'b0;
            #1;
            check_eq(nm("midrst_cs_n"), int'(cs_n), 1);
            check_eq(nm("midrst_spck"), int'(spck), int'(CPOL_L));
            check_eq(nm("midrst_mosi"), int'(mosi), 0);
            check_eq(nm("midrst_rx_en"), int'(rx_en), 0);
            check_eq(nm("midrst_rx_count"), int'(rx_count), 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_eq(nm("midrst_ready"), int'(tx_ready), 1);
            win_data[0] = 8'h96;
            run_window(1, 1, 0);

            mark_done();
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done_cnt < 4; i++) @(negedge clk);
        check_eq("all_sequences_done", done_cnt, 4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
